// File: rtl/header_text_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : header_text_writer
// Description : Byte-stream writer for the header text RAM. Decodes printable
//               ASCII and CR/LF/BS/FF, tracks the cursor, and runs a
//               full-screen clear. Optional macro HEADER_CLEAR_ON_RESET_EN
//               starts a clear automatically when reset is released.
// Revision    : 1.0 - initial release
// ============================================================================
module header_text_writer #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 4,
    parameter int         COL_W      = 7,
    parameter int         ROW_W      = 2,
    parameter logic [6:0] CLEAR_CHAR = 7'h20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   char_valid,
    input  logic [7:0]             char_data,
    output logic                   char_ready,
    output logic                   wr_en,
    output logic [ROW_W+COL_W-1:0] wr_addr,
    output logic [6:0]             wr_data,
    output logic [ROW_W-1:0]       cursor_row,
    output logic [COL_W-1:0]       cursor_col,
    output logic                   busy
);

    localparam logic [COL_W-1:0] c_last_col = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] c_last_row = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_byte;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_clr_row;
    logic [COL_W-1:0] r_clr_col;
    logic [ROW_W-1:0] w_row_nxt;
    logic [COL_W-1:0] w_col_nxt;
    logic [ROW_W-1:0] w_row_inc;
    logic             w_accept;
    logic             w_printable;
    logic             w_clr_last;
    logic             w_start_clear;

`ifdef HEADER_CLEAR_ON_RESET_EN
    logic r_init;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init <= 1'b1;
        end else begin
            r_init <= 1'b0;
        end
    end

    assign w_start_clear = r_init;
`else
    assign w_start_clear = 1'b0;
`endif

    assign char_ready  = reset_n && (r_state == ST_IDLE) && !w_start_clear;
    assign w_accept    = char_valid && char_ready;
    assign busy        = (r_state == ST_CLEAR);
    assign w_printable = (r_byte >= 8'h20) && (r_byte <= 8'h7E);
    assign w_clr_last  = (r_clr_row == c_last_row) && (r_clr_col == c_last_col);
    assign w_row_inc   = (r_row == c_last_row) ? '0 : r_row + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_clear) begin
                    w_state_nxt = ST_CLEAR;
                end else if (w_accept) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_state_nxt = (r_byte == 8'h0C) ? ST_CLEAR : ST_IDLE;
            end
            ST_CLEAR: begin
                if (w_clr_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Cursor only moves in the single WRITE cycle; no scrolling, rows wrap to top.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (r_state == ST_WRITE) begin
            if (w_printable) begin
                if (r_col == c_last_col) begin
                    w_col_nxt = '0;
                    w_row_nxt = w_row_inc;
                end else begin
                    w_col_nxt = r_col + 1'b1;
                end
            end else begin
                case (r_byte)
                    8'h0D: w_col_nxt = '0;
                    8'h0A: begin
                        w_col_nxt = '0;
                        w_row_nxt = w_row_inc;
                    end
                    8'h08: begin
                        if (r_col != '0) begin
                            w_col_nxt = r_col - 1'b1;
                        end
                    end
                    8'h0C: begin
                        w_col_nxt = '0;
                        w_row_nxt = '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // wr_addr/wr_data only change alongside a write strobe, so they hold between writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_byte     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_clr_row  <= '0;
            r_clr_col  <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en      <= 1'b0;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            cursor_row <= r_row;
            cursor_col <= r_col;
            if (w_accept) begin
                r_byte <= char_data;
            end
            case (r_state)
                ST_WRITE: begin
                    if (w_printable) begin
                        wr_en   <= 1'b1;
                        wr_addr <= {r_row, r_col};
                        wr_data <= r_byte[6:0];
                    end
                end
                ST_CLEAR: begin
                    wr_en   <= 1'b1;
                    wr_addr <= {r_clr_row, r_clr_col};
                    wr_data <= CLEAR_CHAR;
                    if (r_clr_col == c_last_col) begin
                        r_clr_col <= '0;
                        r_clr_row <= (r_clr_row == c_last_row) ? '0 : r_clr_row + 1'b1;
                    end else begin
                        r_clr_col <= r_clr_col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
